// File: rtl/fir_tap_sequencer.sv
// rtl/fir_tap_sequencer.sv - serial-MAC sequencer for a 16-tap FIR datapath
//
// Accepts one sample per handshake into a circular delay line, walks the
// coefficient index through an external combinational ROM, accumulates the
// products newest-sample-first, and presents one shifted, saturated result.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_sample, i_sample_valid, o_sample_ready   input sample handshake
//   i_clear                 flush the delay line (honoured only in IDLE)
//   o_coef_idx, i_coef      coefficient ROM index out, coefficient back
//   o_result, o_result_valid, i_result_ready   output sample handshake
//   o_busy                  high whenever not IDLE
module fir_tap_sequencer #(
  parameter int NTAPS  = 16,
  parameter int DW     = 16,
  parameter int CW     = 16,
  parameter int ACCW   = 36,
  parameter int OSHIFT = 15
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [DW-1:0] i_sample,
  input  logic          i_sample_valid,
  output logic          o_sample_ready,
  input  logic          i_clear,
  output logic [4:0]    o_coef_idx,
  input  logic [CW-1:0] i_coef,
  output logic [DW-1:0] o_result,
  output logic          o_result_valid,
  input  logic          i_result_ready,
  output logic          o_busy
);

  localparam int AW = $clog2(NTAPS);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                 state;
  logic [DW-1:0]          dline [NTAPS];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          newest;
  logic [4:0]             k;
  logic signed [ACCW-1:0] acc;

  logic [AW-1:0]            rd_idx;
  logic signed [DW+CW-1:0]  prod;
  logic signed [ACCW-1:0]   prod_ext;
  logic signed [ACCW-1:0]   shifted;

  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  // Tap k reads the sample k steps older than the newest; NTAPS is a power
  // of two so the subtraction wraps modulo the delay-line depth for free.
  assign rd_idx   = newest - k[AW-1:0];
  assign prod     = $signed(dline[rd_idx]) * $signed(i_coef);
  assign prod_ext = {{(ACCW-DW-CW){prod[DW+CW-1]}}, prod};

  // Floor shift, then clamp into the signed DW range.
  assign shifted = acc >>> OSHIFT;

  always_comb begin
    o_result = shifted[DW-1:0];
    if (shifted > SAT_MAX)
      o_result = SAT_MAX[DW-1:0];
    else if (shifted < SAT_MIN)
      o_result = SAT_MIN[DW-1:0];
  end

  assign o_sample_ready = (state == IDLE) && !i_clear;
  // k is only non-zero while in MAC, so it doubles as the ROM index.
  assign o_coef_idx     = k;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      newest         <= '0;
      k              <= '0;
      acc            <= '0;
      o_result_valid <= 1'b0;
      o_busy         <= 1'b0;
      for (int i = 0; i < NTAPS; i++) dline[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_clear) begin
            for (int i = 0; i < NTAPS; i++) dline[i] <= '0;
            wr_ptr <= '0;
          end else if (i_sample_valid) begin
            dline[wr_ptr] <= i_sample;
            newest        <= wr_ptr;
            wr_ptr        <= wr_ptr + AW'(1);
            k             <= '0;
            acc           <= '0;
            o_busy        <= 1'b1;
            state         <= MAC;
          end
        end
        MAC: begin
          acc <= acc + prod_ext;
          if (k == 5'(NTAPS-1)) begin
            k              <= '0;
            o_result_valid <= 1'b1;
            state          <= OUT;
          end else begin
            k <= k + 5'd1;
          end
        end
        OUT: begin
          if (i_result_ready) begin
            o_result_valid <= 1'b0;
            o_busy         <= 1'b0;
            state          <= IDLE;
          end
        end
        default: begin
          state          <= IDLE;
          k              <= '0;
          o_result_valid <= 1'b0;
          o_busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb/tb_fir_tap_sequencer.sv - directed self-checking bench for fir_tap_sequencer
module tb_fir_tap_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [15:0] i_sample;
  logic        i_sample_valid;
  logic        o_sample_ready;
  logic        i_clear;
  logic [4:0]  o_coef_idx;
  logic [15:0] i_coef;
  logic [15:0] o_result;
  logic        o_result_valid;
  logic        i_result_ready;
  logic        o_busy;

  int passed = 0;
  int total  = 0;

  always #5 i_clk = ~i_clk;

  fir_tap_sequencer dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_sample       (i_sample),
    .i_sample_valid (i_sample_valid),
    .o_sample_ready (o_sample_ready),
    .i_clear        (i_clear),
    .o_coef_idx     (o_coef_idx),
    .i_coef         (i_coef),
    .o_result       (o_result),
    .o_result_valid (o_result_valid),
    .i_result_ready (i_result_ready),
    .o_busy         (o_busy)
  );

  // Symmetric coefficient ROM, combinational.
  logic [15:0] rom [16] = '{16'h0565, 16'h0BD9, 16'h0B0B, 16'hFF27,
                            16'hF3A7, 16'hFB52, 16'h182E, 16'h3384,
                            16'h3384, 16'h182E, 16'hFB52, 16'hF3A7,
                            16'hFF27, 16'h0B0B, 16'h0BD9, 16'h0565};
  assign i_coef = rom[o_coef_idx[3:0]];

  // 0x7FFF impulse response: positive taps come out c-1, negative exact.
  logic [15:0] exp_imp [16] = '{16'h0564, 16'h0BD8, 16'h0B0A, 16'hFF27,
                                16'hF3A7, 16'hFB52, 16'h182D, 16'h3383,
                                16'h3383, 16'h182D, 16'hFB52, 16'hF3A7,
                                16'hFF27, 16'h0B0A, 16'h0BD8, 16'h0564};

  task automatic do_reset;
    i_rst_n        = 1'b0;
    i_sample       = '0;
    i_sample_valid = 1'b0;
    i_clear        = 1'b0;
    i_result_ready = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(posedge i_clk); #1;
  endtask

  // Drives one sample through the full handshake; r is X on timeout.
  task automatic send_sample(input logic [15:0] s, output logic [15:0] r);
    int n;
    i_sample       = s;
    i_sample_valid = 1'b1;
    n = 0;
    while (!o_sample_ready && n < 100) begin @(posedge i_clk); #1; n++; end
    @(posedge i_clk); #1;
    i_sample_valid = 1'b0;
    n = 0;
    while (!o_result_valid && n < 100) begin @(posedge i_clk); #1; n++; end
    r = o_result_valid ? o_result : 16'hxxxx;
    i_result_ready = 1'b1;
    @(posedge i_clk); #1;
    i_result_ready = 1'b0;
  endtask

  task automatic test_reset;
    i_rst_n        = 1'b0;
    i_sample       = '0;
    i_sample_valid = 1'b0;
    i_clear        = 1'b0;
    i_result_ready = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    total++;
    if ({o_result_valid, o_busy, o_coef_idx} !== 7'd0)
      $display("FAIL reset_ctrl: valid/busy/idx=%b required 0000000", {o_result_valid, o_busy, o_coef_idx});
    else passed++;
    total++;
    if (o_result !== 16'h0000)
      $display("FAIL reset_result: got %h required 0000", o_result);
    else passed++;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    total++;
    if (o_sample_ready !== 1'b1)
      $display("FAIL reset_ready: got %b required 1", o_sample_ready);
    else passed++;
  endtask

  task automatic test_impulse;
    logic [15:0] r;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      send_sample(i == 0 ? 16'h7FFF : 16'h0000, r);
      total++;
      if (r !== (i < 16 ? exp_imp[i] : 16'h0000))
        $display("FAIL impulse_out%0d: got %h required %h", i, r, (i < 16 ? exp_imp[i] : 16'h0000));
      else passed++;
    end
  endtask

  task automatic test_saturation;
    logic [15:0] r;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      send_sample(16'h7FFF, r);
      if (i == 0) begin
        total++;
        if (r !== 16'h0564) $display("FAIL sat_pos_first: got %h required 0564", r);
        else passed++;
      end
    end
    total++;
    if (r !== 16'h7FFF) $display("FAIL sat_pos: got %h required 7fff", r);
    else passed++;
    for (int i = 0; i < 16; i++) send_sample(16'h8000, r);
    total++;
    if (r !== 16'h8000) $display("FAIL sat_neg: got %h required 8000", r);
    else passed++;
  endtask

  task automatic test_latency_backpressure;
    logic [15:0] held;
    logic        ok;
    do_reset();
    i_sample       = 16'h7FFF;
    i_sample_valid = 1'b1;
    total++;
    if (o_coef_idx !== 5'd0) $display("FAIL idx_idle: got %0d required 0", o_coef_idx);
    else passed++;
    @(posedge i_clk); #1;   // edge N: accepted
    i_sample_valid = 1'b0;
    for (int j = 0; j < 16; j++) begin
      total++;
      if (o_coef_idx !== 5'(j) || o_result_valid !== 1'b0)
        $display("FAIL mac_step%0d: idx=%0d valid=%b required idx=%0d valid=0", j, o_coef_idx, o_result_valid, j);
      else passed++;
      @(posedge i_clk); #1;
    end
    total++;
    if (o_result_valid !== 1'b1 || o_coef_idx !== 5'd0 || o_result !== 16'h0564)
      $display("FAIL latency_out: valid=%b idx=%0d result=%h required 1 0 0564", o_result_valid, o_coef_idx, o_result);
    else passed++;
    held = 16'h0564;
    ok = 1'b1;
    repeat (5) begin
      @(posedge i_clk); #1;
      if (o_result !== held || o_result_valid !== 1'b1 || o_sample_ready !== 1'b0 || o_busy !== 1'b1) ok = 1'b0;
    end
    total++;
    if (!ok) $display("FAIL backpressure_hold: result=%h valid=%b ready=%b busy=%b required %h 1 0 1",
                      o_result, o_result_valid, o_sample_ready, o_busy, held);
    else passed++;
    i_result_ready = 1'b1;
    @(posedge i_clk); #1;
    i_result_ready = 1'b0;
    total++;
    if (o_busy !== 1'b0 || o_result_valid !== 1'b0 || o_sample_ready !== 1'b1)
      $display("FAIL release_idle: busy=%b valid=%b ready=%b required 0 0 1", o_busy, o_result_valid, o_sample_ready);
    else passed++;
  endtask

  // Impulse lands in slot 14; later reads wrap the operand index past 0.
  task automatic test_index_wrap;
    logic [15:0] r;
    do_reset();
    for (int i = 0; i < 14; i++) send_sample(16'h0000, r);
    for (int i = 0; i < 6; i++) begin
      send_sample(i == 0 ? 16'h7FFF : 16'h0000, r);
      total++;
      if (r !== exp_imp[i]) $display("FAIL wrap_out%0d: got %h required %h", i, r, exp_imp[i]);
      else passed++;
    end
  endtask

  task automatic test_clear;
    logic [15:0] r;
    do_reset();
    for (int i = 0; i < 8; i++) send_sample(16'h4000, r);
    i_clear        = 1'b1;
    i_sample       = 16'h1111;
    i_sample_valid = 1'b1;
    #1;
    total++;
    if (o_sample_ready !== 1'b0) $display("FAIL clear_ready: got %b required 0", o_sample_ready);
    else passed++;
    @(posedge i_clk); #1;
    i_clear        = 1'b0;
    i_sample_valid = 1'b0;
    total++;
    if (o_busy !== 1'b0) $display("FAIL clear_not_accepted: busy=%b required 0", o_busy);
    else passed++;
    send_sample(16'h7FFF, r);
    total++;
    if (r !== 16'h0564) $display("FAIL clear_out0: got %h required 0564", r);
    else passed++;
    send_sample(16'h0000, r);
    total++;
    if (r !== 16'h0BD8) $display("FAIL clear_out1: got %h required 0bd8", r);
    else passed++;
  endtask

  task automatic test_reset_mid_mac;
    logic [15:0] r;
    logic        seen;
    do_reset();
    send_sample(16'h4000, r);
    send_sample(16'h4000, r);
    i_sample       = 16'h7FFF;
    i_sample_valid = 1'b1;
    @(posedge i_clk); #1;
    i_sample_valid = 1'b0;
    repeat (7) begin @(posedge i_clk); #1; end
    total++;
    if (o_coef_idx !== 5'd7) $display("FAIL mid_mac_idx: got %0d required 7", o_coef_idx);
    else passed++;
    i_rst_n = 1'b0;
    #1;
    total++;
    if (o_busy !== 1'b0 || o_result_valid !== 1'b0 || o_coef_idx !== 5'd0)
      $display("FAIL mid_mac_abort: busy=%b valid=%b idx=%0d required 0 0 0", o_busy, o_result_valid, o_coef_idx);
    else passed++;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin @(posedge i_clk); #1; if (o_result_valid !== 1'b0) seen = 1'b1; end
    total++;
    if (seen) $display("FAIL mid_mac_no_result: valid seen=1 required 0");
    else passed++;
    for (int i = 0; i < 3; i++) begin
      send_sample(i == 0 ? 16'h7FFF : 16'h0000, r);
      total++;
      if (r !== exp_imp[i]) $display("FAIL post_reset_out%0d: got %h required %h", i, r, exp_imp[i]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_saturation();
    test_latency_backpressure();
    test_index_wrap();
    test_clear();
    test_reset_mid_mac();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
- Sequencer for the 16-tap FIR datapath.
- Accepts one input sample per handshake and stores it in a 16-entry circular delay line.
- Walks the coefficient index 0..15 into the combinational coefficient ROM and accumulates sample×coefficient products serially.
- Presents one saturated output sample per input sample, with valid/ready backpressure.

Parameters:
- NTAPS, 16, number of taps; also delay-line depth; must be a power of two.
- DW, 16, sample and result width, signed two's complement.
- CW, 16, coefficient width, signed two's complement.
- ACCW, 36, accumulator width; ≥ DW+CW+log2(NTAPS).
- OSHIFT, 15, arithmetic right shift applied to the accumulator before saturation.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset; asynchronous assert, active-low.
- i_sample  in  DW  input sample, signed.
- i_sample_valid  in  1  input sample is present.
- o_sample_ready  out  1  block can accept a sample.
- i_clear  in  1  flush the delay line; honoured only in IDLE.
- o_coef_idx  out  5  coefficient index driven to the ROM.
- i_coef  in  CW  coefficient returned by the ROM in the same cycle (combinational).
- o_result  out  DW  filtered output sample, signed.
- o_result_valid  out  1  o_result is valid.
- i_result_ready  in  1  downstream accepts o_result.
- o_busy  out  1  state ≠ IDLE.

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - state=IDLE, all delay-line entries 0, wr_ptr=0, k=0, acc=0.
  - o_result_valid=0, o_coef_idx=0, o_busy=0.
  - o_result=0, since it derives from acc.
- States: IDLE, MAC, OUT.
- IDLE:
  - o_sample_ready = ~i_clear.
  - If i_clear: all entries zeroed and wr_ptr=0 on that edge; any sample is NOT accepted.
  - Else if i_sample_valid: on edge N, buf[wr_ptr]=i_sample, newest=wr_ptr, wr_ptr=wr_ptr+1 mod NTAPS, k=0, acc=0, go to MAC.
- MAC:
  - o_sample_ready=0, o_coef_idx=k.
  - Operand = buf[(newest−k) mod NTAPS]; wrap-around is pure modulo.
  - Each edge: acc += sext(operand × i_coef), with a full-precision signed DW+CW product; k++.
  - The edge with k=NTAPS−1 performs the last accumulate and goes to OUT.
  - Accumulates occur on edges N+1..N+16.
- OUT:
  - o_result_valid=1; o_coef_idx=0.
  - o_result = sat_DW(acc >>> OSHIFT): arithmetic shift (floor), clamp to [0x8000, 0x7FFF].
  - Held stable until i_result_ready=1; on that edge go to IDLE.
- Latency and throughput:
  - Sample accepted at edge N ⇒ o_result_valid high after edge N+16.
  - Minimum sample spacing is 18 cycles with i_result_ready tied high.
  - A new sample is accepted no earlier than the cycle after result hand-off; no overlap.
- Handshake rules:
  - i_sample_valid/i_sample are ignored outside IDLE; the upstream must hold them.
  - i_clear is ignored in MAC and OUT.
- Reset mid-MAC or mid-OUT: operation is abandoned, no result is emitted, the delay line is cleared.
- i_coef is sampled only in MAC; its value in other states is don't-care.

Test Plan:
- Coefficient ROM setup for all scenarios: taps 0x0565, 0x0BD9, 0x0B0B, 0xFF27, 0xF3A7, 0xFB52, 0x182E, 0x3384, mirrored; sum=44086.
- Impulse: send 0x7FFF, then 15 zeros → outputs 0x0564, 0x0BD8, 0x0B0A, 0xFF27, 0xF3A7, ...
  - Positive taps come out as c−1; negative taps come out exact.
  - After 16 samples, the 17th output is 0x0000.
- Saturation:
  - 16 samples of 0x7FFF → 16th output 0x7FFF (unsaturated value 44084).
  - Then 16 samples of 0x8000 → 16th output 0x8000.
- Latency/backpressure:
  - Accept at edge N → o_result_valid rises after edge N+16.
  - Hold i_result_ready low 5 cycles → o_result stable, o_sample_ready=0, o_busy=1.
  - Release → IDLE the next cycle.
- Index sequencing: during MAC, o_coef_idx = 0,1,…,15 on consecutive cycles; it is 0 in IDLE and OUT.
  - After 20 samples (wr_ptr wrapped), the operand order is still newest-first.
- Clear:
  - Load 8 samples of 0x4000, pulse i_clear with i_sample_valid=1 in IDLE → that sample is not accepted.
  - Next impulse of 0x7FFF → output equals tap0 response only (0x0564).
- Reset mid-MAC: deassert i_rst_n at k=7 → o_result_valid never asserts.
  - After release, the impulse test reproduces its expected output sequence from zero history.
